// File: rtl/dsp_mac_sequencer.sv
// Feeds a burst of LEN signed operand pairs into a DSP slice, accumulating in its post-adder via OPMODE.
// Latency: last operand transfer to res_valid is PIPE_LAT+1 cycles with no bubbles.
// Backpressure: s_valid gaps freeze the slice through CE; the result is held until res_ready.
module dsp_mac_sequencer #(
    parameter int LEN      = 8,
    parameter int PIPE_LAT = 4,
    parameter int OPM_DLY  = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    output logic        busy,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic [17:0] dsp_A,
    output logic [17:0] dsp_B,
    output logic [17:0] dsp_D,
    output logic [47:0] dsp_C,
    output logic [7:0]  dsp_OPMODE,
    output logic        dsp_CE,
    output logic        dsp_RST,
    input  logic [47:0] dsp_P,
    input  logic        dsp_CARRYOUT,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] res_data,
    output logic        res_carry
);

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int DW = (PIPE_LAT > 2) ? $clog2(PIPE_LAT - 1) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, CAP, OUT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   op_cnt_q, op_cnt_d;
    logic [DW-1:0]   drn_cnt_q, drn_cnt_d;
    logic [47:0]     res_data_q, res_data_d;
    logic            res_carry_q, res_carry_d;
    logic            xfer;
    logic            ce;
    logic [7:0]      tag;

    always_comb begin
        state_d     = state_q;
        op_cnt_d    = op_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        xfer        = 1'b0;
        ce          = 1'b0;
        tag         = 8'h08;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    op_cnt_d  = '0;
                    drn_cnt_d = '0;
                end
            end
            LOAD: begin
                xfer = s_valid;
                if (s_valid) begin
                    ce  = 1'b1;
                    // First product starts a fresh sum so a stale P never leaks in.
                    tag = (op_cnt_q == '0) ? 8'h01 : 8'h09;
                    if (op_cnt_q == CW'(LEN - 1)) begin
                        op_cnt_d = '0;
                        state_d  = (PIPE_LAT == 1) ? CAP : DRAIN;
                    end else begin
                        op_cnt_d = op_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                ce = 1'b1;
                if (drn_cnt_q == DW'(PIPE_LAT - 2)) begin
                    drn_cnt_d = '0;
                    state_d   = CAP;
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            CAP: begin
                res_data_d  = dsp_P;
                res_carry_d = dsp_CARRYOUT;
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            op_cnt_q    <= '0;
            drn_cnt_q   <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_cnt_q    <= op_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
        end
    end

    // OPMODE tags ride a CE-gated shift register so they stay aligned with frozen slice stages.
    if (OPM_DLY > 0) begin : g_opm
        logic [7:0] opm_q [OPM_DLY];
        logic [7:0] opm_d [OPM_DLY];

        always_comb begin
            for (int i = 0; i < OPM_DLY; i++) opm_d[i] = opm_q[i];
            if (ce) begin
                opm_d[0] = tag;
                for (int i = 1; i < OPM_DLY; i++) opm_d[i] = opm_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (RST) begin
                for (int i = 0; i < OPM_DLY; i++) opm_q[i] <= 8'h08;
            end else begin
                for (int i = 0; i < OPM_DLY; i++) opm_q[i] <= opm_d[i];
            end
        end

        assign dsp_OPMODE = opm_q[OPM_DLY-1];
    end else begin : g_opm_bypass
        assign dsp_OPMODE = tag;
    end

    assign busy      = (state_q != IDLE);
    assign s_ready   = (state_q == LOAD);
    assign res_valid = (state_q == OUT);
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign dsp_A     = xfer ? s_a : '0;
    assign dsp_B     = xfer ? s_b : '0;
    assign dsp_D     = '0;
    assign dsp_C     = '0;
    assign dsp_CE    = ce;
    assign dsp_RST   = RST;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: two instances (LEN=4 and LEN=2), each driving a behavioural DSP slice.
module tb_dsp_mac_sequencer;

    localparam int PL = 4;
    localparam int OD = 2;

    logic        clk = 1'b0;
    logic        RST, start, s_valid, res_ready;
    logic [17:0] s_a, s_b;
    logic        busy [2], s_ready [2], dsp_CE [2], dsp_RST [2];
    logic        res_valid [2], res_carry [2], dsp_CARRYOUT [2];
    logic [17:0] dsp_A [2], dsp_B [2], dsp_D [2];
    logic [47:0] dsp_C [2], dsp_P [2], res_data [2];
    logic [7:0]  dsp_OPMODE [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dsp_mac_sequencer #(.LEN(g == 0 ? 4 : 2), .PIPE_LAT(PL), .OPM_DLY(OD)) u_dut (
            .clk(clk), .RST(RST), .start(start), .busy(busy[g]),
            .s_valid(s_valid), .s_ready(s_ready[g]), .s_a(s_a), .s_b(s_b),
            .dsp_A(dsp_A[g]), .dsp_B(dsp_B[g]), .dsp_D(dsp_D[g]), .dsp_C(dsp_C[g]),
            .dsp_OPMODE(dsp_OPMODE[g]), .dsp_CE(dsp_CE[g]), .dsp_RST(dsp_RST[g]),
            .dsp_P(dsp_P[g]), .dsp_CARRYOUT(dsp_CARRYOUT[g]),
            .res_valid(res_valid[g]), .res_ready(res_ready),
            .res_data(res_data[g]), .res_carry(res_carry[g])
        );

        // Slice model: 3 product stages, then P; OPMODE sampled once more to meet its product.
        logic [47:0] m_q [PL-1];
        logic [7:0]  om_q;
        logic [47:0] p_q;
        logic        c_q;
        logic [47:0] prod, xv, zv;

        assign prod = {{30{dsp_A[g][17]}}, dsp_A[g]} * {{30{dsp_B[g][17]}}, dsp_B[g]};
        assign xv   = (om_q[1:0] == 2'b01) ? m_q[PL-2] : 48'd0;
        assign zv   = (om_q[3:2] == 2'b10) ? p_q : 48'd0;

        always @(posedge clk) begin
            if (dsp_RST[g]) begin
                for (int i = 0; i < PL - 1; i++) m_q[i] <= '0;
                om_q <= 8'h08;
                p_q  <= '0;
                c_q  <= 1'b0;
            end else if (dsp_CE[g]) begin
                m_q[0] <= prod;
                for (int i = 1; i < PL - 1; i++) m_q[i] <= m_q[i-1];
                om_q <= dsp_OPMODE[g];
                {c_q, p_q} <= {1'b0, xv} + {1'b0, zv};
            end
        end

        assign dsp_P[g]        = p_q;
        assign dsp_CARRYOUT[g] = c_q;
    end

    logic       log_en = 1'b0;
    logic [7:0] opm_log [$];
    always @(negedge clk) if (log_en && dsp_CE[0]) opm_log.push_back(dsp_OPMODE[0]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic burst(input int sel, input logic [3:0][17:0] a, input logic [3:0][17:0] b,
                         input int n, input int gap, input bit wait_res,
                         output logic [47:0] d, output logic c, output int lat,
                         output int ce_gap, output bit tmo);
        int w;
        d = '0; c = 1'b0; lat = 0; ce_gap = 0; tmo = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                for (int gi = 0; gi < gap; gi++) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                    if (dsp_CE[sel]) ce_gap++;
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1; s_a = a[k]; s_b = b[k];
            w = 0;
            do begin @(negedge clk); w++; end while (!s_ready[sel] && w < 20);
            if (w >= 20) tmo = 1'b1;
            @(posedge clk); #1;
        end
        s_valid = 1'b0; s_a = '0; s_b = '0;
        if (wait_res) begin
            lat = 1;
            @(negedge clk);
            while (!res_valid[sel] && lat < 50) begin @(negedge clk); lat++; end
            if (lat >= 50) tmo = 1'b1;
            d = res_data[sel];
            c = res_carry[sel];
        end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        int               gap;
        logic [47:0]      exp_d;
        logic             exp_c;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [47:0] d;
        logic        c;
        int          lat, ce_gap;
        bit          tmo;
        logic [7:0]  exp_opm [7];

        vecs[0].a = {18'd4, 18'd3, 18'd2, 18'd1};
        vecs[0].b = {18'd8, 18'd7, 18'd6, 18'd5};
        vecs[0].gap = 0; vecs[0].exp_d = 48'd70; vecs[0].exp_c = 1'b0;
        vecs[1] = vecs[0]; vecs[1].gap = 2;
        vecs[2].a = {4{18'h3FFFF}};
        vecs[2].b = {4{18'd1}};
        vecs[2].gap = 0; vecs[2].exp_d = 48'hFFFF_FFFF_FFFC; vecs[2].exp_c = 1'b1;
        vecs[3].a = {4{18'h1FFFF}};
        vecs[3].b = {4{18'h20000}};
        vecs[3].gap = 1; vecs[3].exp_d = 48'hFFF0_0008_0000; vecs[3].exp_c = 1'b1;
        vecs[4].a = {4{18'h20000}};
        vecs[4].b = {4{18'h20000}};
        vecs[4].gap = 0; vecs[4].exp_d = 48'h0010_0000_0000; vecs[4].exp_c = 1'b0;
        exp_opm = '{8'h08, 8'h08, 8'h01, 8'h09, 8'h09, 8'h09, 8'h08};

        // Reset with random inputs
        RST = 1'b1; start = 1'b0; s_valid = 1'b0; res_ready = 1'b0; s_a = '0; s_b = '0;
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); s_valid = 1'($urandom); res_ready = 1'($urandom);
            s_a = 18'($urandom); s_b = 18'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_busy", busy[0], 0);
        chk("rst_s_ready", s_ready[0], 0);
        chk("rst_dsp_ce", dsp_CE[0], 0);
        chk("rst_res_valid", res_valid[0], 0);
        chk("rst_res_data", res_data[0], 0);
        chk("rst_dsp_rst", dsp_RST[0], 1);
        chk("rst_dsp_c_d", {dsp_C[0], dsp_D[0]}, 0);
        @(posedge clk); #1;
        RST = 1'b0; start = 1'b0; s_valid = 1'b0; res_ready = 1'b0; s_a = '0; s_b = '0;
        @(negedge clk);
        chk("dsp_rst_released", dsp_RST[0], 0);

        // Table-driven bursts on the LEN=4 instance
        for (int r = 0; r < 5; r++) begin
            log_en = (r == 0);
            burst(0, vecs[r].a, vecs[r].b, 4, vecs[r].gap, 1'b1, d, c, lat, ce_gap, tmo);
            log_en = 1'b0;
            chk($sformatf("row%0d_timeout", r), tmo, 0);
            chk($sformatf("row%0d_res_data", r), d, vecs[r].exp_d);
            chk($sformatf("row%0d_res_carry", r), c, vecs[r].exp_c);
            if (vecs[r].gap == 0) chk($sformatf("row%0d_latency", r), lat, PL + 1);
            else chk($sformatf("row%0d_ce_in_gap", r), ce_gap, 0);
            accept();
            @(negedge clk);
            chk($sformatf("row%0d_idle_after_accept", r), busy[0], 0);
        end

        chk("opm_log_len", opm_log.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < opm_log.size()) chk($sformatf("opm_log%0d", i), opm_log[i], exp_opm[i]);

        // Result held under backpressure, start ignored in OUT
        burst(0, vecs[0].a, vecs[0].b, 4, 0, 1'b1, d, c, lat, ce_gap, tmo);
        chk("hold_timeout", tmo, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 start = (i % 2 == 0);
            @(negedge clk);
            chk($sformatf("hold%0d_res_valid", i), res_valid[0], 1);
            chk($sformatf("hold%0d_res_data", i), res_data[0], 48'd70);
            chk($sformatf("hold%0d_s_ready", i), s_ready[0], 0);
        end
        @(posedge clk); #1 start = 1'b0;
        accept();
        @(negedge clk);
        chk("hold_idle_after_accept", busy[0], 0);
        @(negedge clk);
        chk("hold_start_not_latched", busy[0], 0);

        // Reset mid-burst, then a clean burst must carry no residue
        burst(0, vecs[0].a, vecs[0].b, 2, 0, 1'b0, d, c, lat, ce_gap, tmo);
        chk("midrst_partial_timeout", tmo, 0);
        RST = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 RST = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy[0], 0);
        burst(0, {4{18'd2}}, {4{18'd2}}, 4, 0, 1'b1, d, c, lat, ce_gap, tmo);
        chk("midrst_timeout", tmo, 0);
        chk("midrst_res_data", d, 48'd16);
        chk("midrst_res_carry", c, 0);
        accept();

        // LEN=2 instance with mixed signs
        RST = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 RST = 1'b0;
        burst(1, {18'd0, 18'd0, 18'd100, 18'h3FFFD}, {18'd0, 18'd0, 18'h3FFFE, 18'd7},
              2, 0, 1'b1, d, c, lat, ce_gap, tmo);
        chk("len2_timeout", tmo, 0);
        chk("len2_res_data", d, 48'hFFFF_FFFF_FF23);
        chk("len2_res_carry", c, 1);
        chk("len2_latency", lat, PL + 1);
        accept();
        @(negedge clk);
        chk("len2_idle_after_accept", busy[1], 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
